// File: rtl/msg_modulator.sv
// msg_modulator: turns a serial message bit stream into 8-bit DAC samples
// using ASK, FSK or BPSK on a sine carrier taken from a 10-bit phase
// accumulator and a quarter-wave sine table.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   msg_bit    serial message bit (held for one bit period)
//   valid      frame-active qualifier
//   mod_sel    00 ASK, 01 FSK, 10 BPSK, 11 reserved (midscale output)
//   dac_out    unsigned DAC sample, 128 = midscale
//   out_valid  dac_out carries a frame sample (valid delayed one clk)
//   frame_done one-clk pulse after a frame ends
module msg_modulator #(
  parameter logic [9:0] F0_STEP = 10'd1,
  parameter logic [9:0] F1_STEP = 10'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_bit,
  input  logic       valid,
  input  logic [1:0] mod_sel,
  output logic [7:0] dac_out,
  output logic       out_valid,
  output logic       frame_done
);

  localparam int unsigned PHASE_W = 10;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DAC_W   = 8;

  localparam logic [1:0] MODE_ASK  = 2'b00;
  localparam logic [1:0] MODE_FSK  = 2'b01;
  localparam logic [1:0] MODE_BPSK = 2'b10;

  localparam logic [DAC_W-1:0] MIDSCALE = 8'd128;

  // round(127*sin(2*pi*i/256)) for i = 0..63
  localparam logic [6:0] QSIN [64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  logic [PHASE_W-1:0] phase;
  logic [1:0]         mode_r;

  logic [PHASE_W-1:0] step_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [DAC_W-1:0]   sample_c;
  logic [DAC_W-1:0]   next_dac_c;

  // Full-wave sine from the quarter table; the second and fourth quadrants
  // read the table mirrored, and their idx=0 point is the 127 peak that the
  // 64-entry table does not hold.
  function automatic logic [DAC_W-1:0] sine(input logic [ADDR_W-1:0] a);
    logic [5:0] idx;
    logic [6:0] mag;
    idx = a[5:0];
    if (a[6]) begin
      if (idx == 6'd0) mag = 7'd127;
      else             mag = QSIN[6'd0 - idx];
    end else begin
      mag = QSIN[idx];
    end
    if (a[7]) sine = 8'(MIDSCALE - {1'b0, mag});
    else      sine = 8'(MIDSCALE + {1'b0, mag});
  endfunction

  // Phase step, table address (BPSK '0' adds half a turn) and sample select
  always_comb begin
    step_c     = F0_STEP;
    addr_c     = phase[9:2];
    next_dac_c = MIDSCALE;
    if (mode_r == MODE_FSK && msg_bit) step_c = F1_STEP;
    if (mode_r == MODE_BPSK && !msg_bit) addr_c = 8'(phase[9:2] + 8'd128);
    sample_c = sine(addr_c);
    case (mode_r)
      MODE_ASK:  next_dac_c = msg_bit ? sample_c : MIDSCALE;
      MODE_FSK:  next_dac_c = sample_c;
      MODE_BPSK: next_dac_c = sample_c;
      default:   next_dac_c = MIDSCALE;
    endcase
  end

  // Accumulator, mode capture while idle, and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      mode_r     <= MODE_ASK;
      dac_out    <= MIDSCALE;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= valid;
      frame_done <= out_valid & ~valid;
      if (valid) begin
        phase   <= PHASE_W'(phase + step_c);
        dac_out <= next_dac_c;
      end else begin
        phase   <= '0;
        mode_r  <= mod_sel;
        dac_out <= MIDSCALE;
      end
    end
  end

endmodule

// File: tb/tb_msg_modulator.sv
// Self-checking bench for msg_modulator: directed carrier spot checks plus
// randomized traffic compared against a real-valued sine reference model.
module tb_msg_modulator;

  localparam int F0 = 1;
  localparam int F1 = 2;
  localparam real PI = 3.14159265358979323846;

  logic       clk;
  logic       rst;
  logic       msg_bit;
  logic       valid;
  logic [1:0] mod_sel;
  logic [7:0] dac_out;
  logic       out_valid;
  logic       frame_done;

  int n_tests;
  int n_fail;

  // reference model state: phase as a plain integer, latched mode, flags
  int m_phase;
  int m_mode;
  int m_ov;

  msg_modulator #(.F0_STEP(10'(F0)), .F1_STEP(10'(F1))) dut (
    .clk(clk), .rst(rst), .msg_bit(msg_bit), .valid(valid),
    .mod_sel(mod_sel), .dac_out(dac_out), .out_valid(out_valid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int s_ref(input int p);
    real x;
    x = 127.0 * $sin(2.0 * PI * real'(p) / 256.0);
    if (x >= 0.0) return 128 + $rtoi(x + 0.5);
    return 128 - $rtoi(0.5 - x);
  endfunction

  function automatic int f_ref(input int ph, input int b, input int mode);
    int p;
    p = ph / 4;
    case (mode)
      0: return (b != 0) ? s_ref(p) : 128;
      1: return s_ref(p);
      2: return (b != 0) ? s_ref(p) : s_ref((p + 128) % 256);
      default: return 128;
    endcase
  endfunction

  // One clock with given inputs; model predicts, outputs checked after edge.
  task automatic tick(input logic v, input logic b, input logic [1:0] sel);
    int e_dac;
    int e_fd;
    valid   = v;
    msg_bit = b;
    mod_sel = sel;
    if (v) begin
      e_dac   = f_ref(m_phase, int'(b), m_mode);
      m_phase = (m_phase + ((m_mode == 1 && b) ? F1 : F0)) % 1024;
    end else begin
      e_dac   = 128;
      m_phase = 0;
      m_mode  = int'(sel);
    end
    e_fd = (m_ov != 0 && !v) ? 1 : 0;
    m_ov = v ? 1 : 0;
    @(posedge clk);
    #1;
    check("dac_out", int'(dac_out), e_dac);
    check("out_valid", int'(out_valid), m_ov);
    check("frame_done", int'(frame_done), e_fd);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_mode  = 0;
    m_ov    = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst = 1'b1; valid = 1'b0; msg_bit = 1'b0; mod_sel = 2'b00;
    #12;
    check("rst_dac", int'(dac_out), 128);
    check("rst_ov", int'(out_valid), 0);
    check("rst_fd", int'(frame_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ASK, msg_bit=1
    tick(1'b0, 1'b1, 2'b00);
    for (int k = 0; k < 1024; k++) begin
      tick(1'b1, 1'b1, 2'b00);
      case (k)
        0:   begin check("ask1_k0", int'(dac_out), 128); check("ask1_ov0", int'(out_valid), 1); end
        256: check("ask1_k256", int'(dac_out), 255);
        512: check("ask1_k512", int'(dac_out), 128);
        768: check("ask1_k768", int'(dac_out), 1);
        default: ;
      endcase
    end
    tick(1'b0, 1'b0, 2'b00);
    check("ask1_end_fd", int'(frame_done), 1);

    // ASK, msg_bit=0
    for (int k = 0; k < 1024; k++) begin
      tick(1'b1, 1'b0, 2'b00);
      if (k == 256) check("ask0_k256", int'(dac_out), 128);
    end
    tick(1'b0, 1'b0, 2'b01);

    // FSK, bit 1 then bit 0 (phase continuous)
    for (int k = 0; k < 1024; k++) begin
      tick(1'b1, (k < 512) ? 1'b1 : 1'b0, 2'b01);
      case (k)
        128: check("fsk_k128", int'(dac_out), 255);
        384: check("fsk_k384", int'(dac_out), 1);
        768: check("fsk_k768", int'(dac_out), 255);
        default: ;
      endcase
    end
    tick(1'b0, 1'b0, 2'b10);

    // BPSK, msg_bit=0 then msg_bit=1
    for (int k = 0; k < 1024; k++) begin
      tick(1'b1, 1'b0, 2'b10);
      case (k)
        0:   check("bpsk0_k0", int'(dac_out), 128);
        256: check("bpsk0_k256", int'(dac_out), 1);
        768: check("bpsk0_k768", int'(dac_out), 255);
        default: ;
      endcase
    end
    tick(1'b0, 1'b0, 2'b10);
    for (int k = 0; k < 300; k++) begin
      tick(1'b1, 1'b1, 2'b10);
      if (k == 256) check("bpsk1_k256", int'(dac_out), 255);
    end
    tick(1'b0, 1'b0, 2'b01);

    // Full 9-bit frame in FSK with mod_sel churning mid-frame
    for (int bitn = 0; bitn < 9; bitn++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      for (int k = 0; k < 1024; k++)
        tick(1'b1, b, 2'($urandom_range(0, 3)));
    end
    tick(1'b0, 1'b0, 2'b00);
    check("full_end_dac", int'(dac_out), 128);
    check("full_end_ov", int'(out_valid), 0);
    check("full_end_fd", int'(frame_done), 1);
    tick(1'b0, 1'b0, 2'b01);
    check("full_fd_once", int'(frame_done), 0);

    // One-cycle valid gap, new frame in reserved mode
    for (int k = 0; k < 300; k++) tick(1'b1, 1'b1, 2'b00);
    tick(1'b0, 1'b1, 2'b11);
    check("gap_fd", int'(frame_done), 1);
    tick(1'b1, 1'b1, 2'b01);
    check("gap_k0_dac", int'(dac_out), 128);
    check("gap_k0_ov", int'(out_valid), 1);
    for (int k = 0; k < 100; k++) tick(1'b1, 1'($urandom_range(0, 1)), 2'b00);
    check("res_dac", int'(dac_out), 128);
    tick(1'b0, 1'b0, 2'b01);

    // Asynchronous reset mid-frame: immediate effect, no frame_done after
    for (int k = 0; k < 100; k++) tick(1'b1, 1'b1, 2'b01);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_dac", int'(dac_out), 128);
    check("arst_ov", int'(out_valid), 0);
    check("arst_fd", int'(frame_done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1'b0, 1'b0, 2'b00);
    check("arst_no_fd", int'(frame_done), 0);
    tick(1'b0, 1'b0, 2'b00);

    // Randomized traffic: short frames, changing bits and modes
    for (int k = 0; k < 4000; k++)
      tick(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
